// File: rtl/lzd_share_arb.sv
// lzd_share_arb
//
// Shares one leading-zero-detect and normalize datapath between NREQ requesters.
// Requesters are chosen round-robin. Each accepted operand goes through two
// registered stages: the operand register s1, then the result register s2.
// Results leave on one valid/ready channel, tagged with the requester id.
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   reset      - asynchronous, active-high reset
//   req_valid  - per-requester operand valid
//   req_data   - operands; requester i drives bits [i*N +: N]
//   req_ready  - per-requester accept; at most one bit is high in any cycle
//   res_valid  - result valid
//   res_ready  - the consumer accepts the result
//   res_id     - index of the requester that produced the result
//   res_count  - leading-zero count of the operand (N-1 when the operand is zero)
//   res_zero   - the operand was all zeros
//   res_norm   - the operand shifted left by res_count
module lzd_share_arb #(
    parameter int unsigned  N    = 32,
    parameter int unsigned  NREQ = 4,
    localparam int unsigned S    = $clog2(N),
    localparam int unsigned I    = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*N-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [I-1:0]        res_id,
    output logic [S-1:0]        res_count,
    output logic                res_zero,
    output logic [N-1:0]        res_norm
);

    logic [I-1:0]    ptr_q;
    logic            s1_v_q;
    logic [N-1:0]    s1_data_q;
    logic [I-1:0]    s1_id_q;

    logic            adv1, adv2;
    logic [NREQ-1:0] grant;
    logic [I-1:0]    grant_id;
    logic            found;
    logic            transfer;
    int unsigned     idx;

    logic [S-1:0]    lz_count;
    logic            lz_found;
    logic            lz_zero;
    logic [N-1:0]    lz_norm;

    assign adv2 = ~res_valid | res_ready;
    assign adv1 = ~s1_v_q | adv2;

    // Scan ptr+1, ptr+2, ... modulo NREQ; the first valid requester wins.
    // Ids >= NREQ are never produced by the modulo, so they are skipped.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!found && req_valid[I'(idx)]) begin
                found          = 1'b1;
                grant[I'(idx)] = 1'b1;
                grant_id       = I'(idx);
            end
        end
    end

    assign req_ready = reset ? '0 : (grant & {NREQ{adv1}});
    assign transfer  = found & adv1 & ~reset;

    // Leading-zero count, scanning from the MSB. An all-zero operand falls
    // through with the default count of N-1.
    always_comb begin
        lz_count = S'(N - 1);
        lz_found = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!lz_found && s1_data_q[S'(N - 1 - j)]) begin
                lz_found = 1'b1;
                lz_count = S'(j);
            end
        end
    end

    assign lz_zero = ~|s1_data_q;
    // A zero operand shifts to zero by itself, so it needs no special case.
    assign lz_norm = s1_data_q << lz_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= I'(NREQ - 1);
            s1_v_q    <= 1'b0;
            s1_data_q <= '0;
            s1_id_q   <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_count <= '0;
            res_zero  <= 1'b0;
            res_norm  <= '0;
        end else begin
            if (adv1) begin
                s1_v_q <= transfer;
                if (transfer) begin
                    s1_data_q <= req_data[32'(grant_id) * N +: N];
                    s1_id_q   <= grant_id;
                    ptr_q     <= grant_id;
                end
            end
            if (adv2) begin
                res_valid <= s1_v_q;
                if (s1_v_q) begin
                    res_id    <= s1_id_q;
                    res_count <= lz_count;
                    res_zero  <= lz_zero;
                    res_norm  <= lz_norm;
                end
            end
        end
    end

endmodule
